mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported unified instruction/data memory between the fetch stage and the load/store stage of the MIPS pipeline. It accepts one request at a time from each requester and arbitrates when both want the port in the same decision cycle. It sequences the fixed-latency memory access and returns word or byte-extracted read data with a one-cycle valid pulse. The decoder's memory-op, write-op, byte-op and unsigned-op control signals drive the load/store request fields directly.

## Interface
- MEM_LATENCY, 2: cycles from `w_mem_en` to valid `w_mem_rdata_32`; legal range 1..7.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- w_if_req  in  1  fetch request; held until `w_if_gnt`.
- w_if_addr_32  in  32  fetch address; bits [1:0] ignored.
- w_if_gnt  out  1  one-cycle pulse, fetch access issued.
- w_if_valid  out  1  one-cycle pulse, `w_if_rdata_32` valid.
- w_if_rdata_32  out  32  fetched word.
- w_ls_req  in  1  load/store request (decoder `w_mem_op`).
- w_ls_write  in  1  1 = store (decoder `w_write_op`).
- w_ls_byte  in  1  byte access (decoder `w_byte_op`).
- w_ls_unsigned  in  1  zero-extend byte load (decoder `w_unsigned_op`).
- w_ls_addr_32  in  32  data address.
- w_ls_wdata_32  in  32  store data; a byte store uses [7:0].
- w_ls_gnt  out  1  one-cycle pulse, data access issued.
- w_ls_valid  out  1  one-cycle pulse, load data valid or store complete.
- w_ls_rdata_32  out  32  load result, extended per byte/unsigned; 0 for stores.
- w_mem_en  out  1  memory access strobe, one cycle per access.
- w_mem_we  out  1  write enable, qualified by `w_mem_en`.
- w_mem_addr_32  out  32  word address with [1:0] forced to 00.
- w_mem_wdata_32  out  32  write data.
- w_mem_byte_en_4  out  4  lane enables; bit 3 = bits [31:24].
- w_mem_rdata_32  in  32  read data, valid exactly MEM_LATENCY cycles after `w_mem_en`.
- w_busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: no access in progress.
  - ISSUE: one cycle. `w_mem_en`=1 and the matching gnt pulses. The request is latched in the decision cycle.
  - WAIT: a 3-bit counter runs from MEM_LATENCY-1 down to 0. `w_mem_rdata_32` is captured in the cycle the counter reaches 0.
  - RESP: one cycle. The matching valid pulses with the registered data.
- Transitions:
  - IDLE to ISSUE: when any request is present.
  - ISSUE to WAIT.
  - WAIT to RESP: when the counter equals 0.
  - RESP to ISSUE: when a request is present. There is no IDLE bubble.
  - RESP to IDLE: when no request is present.
- Decision cycles are IDLE and RESP; requests are sampled only there.
- Arbitration:
  - A single requester wins outright.
  - When both request, the winner is the one not granted last, tracked by a `last_ls` flag.
  - Reset sets `last_ls`=0, so the first contended access goes to load/store.
- A requester may drop its req before gnt; this is a withdrawal, and nothing is issued for it.
- Byte lanes are big-endian: addr[1:0]=00 selects lane 3 (bits [31:24]) and 11 selects lane 0.
- Byte store:
  - `w_mem_byte_en_4` is one-hot for the selected lane.
  - `w_mem_wdata_32` = {4{wdata[7:0]}}.
- Byte load: the selected lane is sign-extended, or zero-extended when unsigned.
- Word access: byte_en = 1111 and addr[1:0] is ignored.
- Stores follow the same timing as loads; `w_ls_valid` marks completion and `w_ls_rdata_32` = 0.
- Fetch requests are always word reads.

## Timing
- Latency: req sampled at cycle N gives gnt/mem_en at N+1 and valid at N+2+MEM_LATENCY.
- Back-to-back accesses issue every MEM_LATENCY+2 cycles.
- Reset values: every output 0, state IDLE, counter 0, `last_ls`=0.
- Reset asserted mid-access:
  - The in-flight access is dropped and no valid is produced.
  - The memory response that follows is ignored.
- gnt and valid never assert for both requesters in the same cycle.
- Memory outputs hold their issued values through WAIT and return to 0 in IDLE.

## Configuration
- MEM_ARB_BYTE_EN defined: byte lane steering, one-hot byte enables and load extension as described above.
- MEM_ARB_BYTE_EN undefined:
  - `w_ls_byte` and `w_ls_unsigned` are ignored.
  - All accesses are word accesses with byte_en = 1111.
  - `w_ls_rdata_32` = raw memory word.

## Test plan
- Fetch only: req at 0x0000_0040, memory returns 0x2408_0005 -> gnt at N+1, `w_mem_addr_32`=0x40, `w_if_valid` at N+4 with 0x2408_0005.
- Contention after reset: both request in the same cycle -> load/store granted first, then fetch issued on the cycle following RESP with no IDLE, then load/store granted again if still requesting.
- Byte load:
  - Memory word 0x1280_FF34 at address 0x102, LB -> `w_ls_rdata_32`=0xFFFF_FFFF.
  - Same access as LBU -> 0x0000_00FF.
  - Address 0x101 -> 0xFFFF_FF80.
- Byte store: SB of 0xAB at 0x203 -> `w_mem_byte_en_4`=0001, `w_mem_wdata_32`=0xABAB_ABAB, `w_mem_addr_32`=0x200, `w_mem_we`=1, `w_ls_valid` with rdata 0.
- Reset during WAIT: reset_n low for 1 cycle after ISSUE -> all outputs 0, no valid pulse, next request is serviced normally.
- Run with MEM_LATENCY=1 and with 7 -> valid appears at exactly N+3 and N+9 respectively.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified single-port memory between fetch and load/store.
// Define MEM_ARB_BYTE_EN for byte lane steering, one-hot byte enables and load extension.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_if_req,
    input  logic [31:0] w_if_addr_32,
    output logic        w_if_gnt,
    output logic        w_if_valid,
    output logic [31:0] w_if_rdata_32,
    input  logic        w_ls_req,
    input  logic        w_ls_write,
    input  logic        w_ls_byte,
    input  logic        w_ls_unsigned,
    input  logic [31:0] w_ls_addr_32,
    input  logic [31:0] w_ls_wdata_32,
    output logic        w_ls_gnt,
    output logic        w_ls_valid,
    output logic [31:0] w_ls_rdata_32,
    output logic        w_mem_en,
    output logic        w_mem_we,
    output logic [31:0] w_mem_addr_32,
    output logic [31:0] w_mem_wdata_32,
    output logic [3:0]  w_mem_byte_en_4,
    input  logic [31:0] w_mem_rdata_32,
    output logic        w_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  count;
    logic        last_ls;
    logic        sel_ls;
    logic        req_write;
    logic        req_byte;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] data;
    logic        decide;
    logic        any_req;
    logic        grant_ls;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  lane_en;

    assign decide   = (state == IDLE) || (state == RESP);
    assign any_req  = w_if_req || w_ls_req;
    // Contended: load/store wins unless it was the last one granted.
    assign grant_ls = w_ls_req && (!w_if_req || !last_ls);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (count == '0) next_state = RESP;
            RESP:    next_state = any_req ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            last_ls      <= 1'b0;
            sel_ls       <= 1'b0;
            req_write    <= 1'b0;
            req_byte     <= 1'b0;
            req_unsigned <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            data         <= '0;
        end else begin
            if (decide && any_req) begin
                sel_ls       <= grant_ls;
                last_ls      <= grant_ls;
                req_write    <= grant_ls && w_ls_write;
                req_byte     <= grant_ls && w_ls_byte;
                req_unsigned <= grant_ls && w_ls_unsigned;
                req_addr     <= grant_ls ? w_ls_addr_32 : w_if_addr_32;
                req_wdata    <= grant_ls ? w_ls_wdata_32 : '0;
            end
            if (state == ISSUE) begin
                count <= 3'(MEM_LATENCY - 1);
            end else if (state == WAIT && count != '0) begin
                count <= count - 3'd1;
            end
            if (state == WAIT && count == '0) begin
                data <= req_write ? '0 : (sel_ls ? load_data : w_mem_rdata_32);
            end
        end
    end

`ifdef MEM_ARB_BYTE_EN
    logic [7:0] lane_byte;

    // Big-endian lanes: address offset 0 is the most significant byte.
    always_comb begin
        case (req_addr[1:0])
            2'b00:   lane_byte = w_mem_rdata_32[31:24];
            2'b01:   lane_byte = w_mem_rdata_32[23:16];
            2'b10:   lane_byte = w_mem_rdata_32[15:8];
            default: lane_byte = w_mem_rdata_32[7:0];
        endcase
        if (!req_byte) begin
            load_data = w_mem_rdata_32;
        end else if (req_unsigned) begin
            load_data = {24'h000000, lane_byte};
        end else begin
            load_data = {{24{lane_byte[7]}}, lane_byte};
        end
        lane_en    = req_byte ? (4'b1000 >> req_addr[1:0]) : 4'b1111;
        store_data = req_byte ? {4{req_wdata[7:0]}} : req_wdata;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{req_byte, req_unsigned, req_addr[1:0]};

    always_comb begin
        load_data  = w_mem_rdata_32;
        lane_en    = 4'b1111;
        store_data = req_wdata;
    end
`endif

    always_comb begin
        w_busy          = (state != IDLE);
        w_mem_en        = (state == ISSUE);
        w_if_gnt        = (state == ISSUE) && !sel_ls;
        w_ls_gnt        = (state == ISSUE) && sel_ls;
        w_if_valid      = (state == RESP) && !sel_ls;
        w_ls_valid      = (state == RESP) && sel_ls;
        w_if_rdata_32   = w_if_valid ? data : '0;
        w_ls_rdata_32   = w_ls_valid ? data : '0;
        w_mem_we        = 1'b0;
        w_mem_addr_32   = '0;
        w_mem_wdata_32  = '0;
        w_mem_byte_en_4 = '0;
        if (state == ISSUE || state == WAIT) begin
            w_mem_we        = req_write;
            w_mem_addr_32   = {req_addr[31:2], 2'b00};
            w_mem_wdata_32  = req_write ? store_data : '0;
            w_mem_byte_en_4 = lane_en;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-level transaction model plus directed scenarios.
// Follows MEM_ARB_BYTE_EN the same way the design does.
module tb_mem_arbiter;

    localparam int LAT = 2;
`ifdef MEM_ARB_BYTE_EN
    localparam bit BYTE_MODE = 1'b1;
`else
    localparam bit BYTE_MODE = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_write, ls_byte, ls_unsigned, ls_gnt, ls_valid;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    mem_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .w_if_req(if_req), .w_if_addr_32(if_addr), .w_if_gnt(if_gnt),
        .w_if_valid(if_valid), .w_if_rdata_32(if_rdata),
        .w_ls_req(ls_req), .w_ls_write(ls_write), .w_ls_byte(ls_byte),
        .w_ls_unsigned(ls_unsigned), .w_ls_addr_32(ls_addr), .w_ls_wdata_32(ls_wdata),
        .w_ls_gnt(ls_gnt), .w_ls_valid(ls_valid), .w_ls_rdata_32(ls_rdata),
        .w_mem_en(mem_en), .w_mem_we(mem_we), .w_mem_addr_32(mem_addr),
        .w_mem_wdata_32(mem_wdata), .w_mem_byte_en_4(mem_be),
        .w_mem_rdata_32(mem_rdata), .w_busy(busy)
    );

    // Latency-1 and latency-7 instances, fetch only.
    logic        r1, g1, v1, e1, we1, bz1, lg1, lv1;
    logic [31:0] rd1, a1o, md1, wd1, lr1;
    logic [3:0]  be1;
    logic        r7, g7, v7, e7, we7, bz7, lg7, lv7;
    logic [31:0] rd7, a7o, md7, wd7, lr7;
    logic [3:0]  be7;
    logic [31:0] small_addr;

    mem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .w_if_req(r1), .w_if_addr_32(small_addr), .w_if_gnt(g1),
        .w_if_valid(v1), .w_if_rdata_32(rd1),
        .w_ls_req(1'b0), .w_ls_write(1'b0), .w_ls_byte(1'b0),
        .w_ls_unsigned(1'b0), .w_ls_addr_32(32'h0), .w_ls_wdata_32(32'h0),
        .w_ls_gnt(lg1), .w_ls_valid(lv1), .w_ls_rdata_32(lr1),
        .w_mem_en(e1), .w_mem_we(we1), .w_mem_addr_32(a1o),
        .w_mem_wdata_32(wd1), .w_mem_byte_en_4(be1),
        .w_mem_rdata_32(md1), .w_busy(bz1)
    );

    mem_arbiter #(.MEM_LATENCY(7)) dut7 (
        .clock(clock), .reset_n(reset_n),
        .w_if_req(r7), .w_if_addr_32(small_addr), .w_if_gnt(g7),
        .w_if_valid(v7), .w_if_rdata_32(rd7),
        .w_ls_req(1'b0), .w_ls_write(1'b0), .w_ls_byte(1'b0),
        .w_ls_unsigned(1'b0), .w_ls_addr_32(32'h0), .w_ls_wdata_32(32'h0),
        .w_ls_gnt(lg7), .w_ls_valid(lv7), .w_ls_rdata_32(lr7),
        .w_mem_en(e7), .w_mem_we(we7), .w_mem_addr_32(a7o),
        .w_mem_wdata_32(wd7), .w_mem_byte_en_4(be7),
        .w_mem_rdata_32(md7), .w_busy(bz7)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_init(input int i);
        case (i)
            16:      return 32'h2408_0005;
            64:      return 32'h1280_FF34;
            128:     return 32'h1122_3344;
            default: return {8'hA5, 8'(i), 8'h5A, 8'(255 - i)};
        endcase
    endfunction

    // Memories: read data is driven only in the exact cycle it is due, garbage otherwise.
    logic [31:0] mem [256];
    logic [31:0] pend;
    logic [7:0]  pv;
    logic [7:0]  sr1, sr7;
    logic [31:0] la1, la7;

    assign mem_rdata = pv[LAT-1] ? pend : 32'hDEAD_BEEF;
    assign md1 = sr1[0] ? ~la1 : 32'hDEAD_BEEF;
    assign md7 = sr7[6] ? ~la7 : 32'hDEAD_BEEF;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
        pv = '0; sr1 = '0; sr7 = '0; pend = '0; la1 = '0; la7 = '0;
        forever begin
            @(posedge clock);
            pv  <= {pv[6:0], mem_en};
            sr1 <= {sr1[6:0], e1};
            sr7 <= {sr7[6:0], e7};
            if (e1) la1 <= a1o;
            if (e7) la7 <= a7o;
            if (mem_en) begin
                pend <= mem[mem_addr[9:2]];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Transaction model: one access per decision, next decision LAT+2 cycles later.
    logic [31:0] ref_mem [256];
    int          free_cyc, iss_cyc, resp_cyc;
    bit          m_ls, last_m, m_we, m_chk_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    int          if_vcyc, ls_vcyc, ls_gcyc;
    logic [31:0] if_vdata, ls_vdata, st_addr, st_wdata;
    logic [3:0]  st_be;
    logic        st_we;

    initial begin
        int          lane;
        bit          by, exp_busy;
        logic [31:0] word;
        logic [7:0]  bv;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
        free_cyc = 0; iss_cyc = -10; resp_cyc = -10; m_ls = 0; last_m = 0;
        m_we = 0; m_chk_be = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
        if_vcyc = -1; ls_vcyc = -1; ls_gcyc = -1;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("reset_ctl", {busy, if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we, mem_be}, '0);
                check("reset_addr_wdata", {mem_addr, mem_wdata}, '0);
                check("reset_rdata", {if_rdata, ls_rdata}, '0);
                free_cyc = 0; iss_cyc = -10; resp_cyc = -10; last_m = 0;
                continue;
            end
            exp_busy = (cyc >= iss_cyc) && (cyc <= resp_cyc);
            check("busy", busy, exp_busy);
            check("if_gnt", if_gnt, cyc == iss_cyc && !m_ls);
            check("ls_gnt", ls_gnt, cyc == iss_cyc && m_ls);
            check("mem_en", mem_en, cyc == iss_cyc);
            check("if_valid", if_valid, cyc == resp_cyc && !m_ls);
            check("ls_valid", ls_valid, cyc == resp_cyc && m_ls);
            if (cyc == resp_cyc && !m_ls) check("if_rdata", if_rdata, m_rdata);
            if (cyc == resp_cyc && m_ls) check("ls_rdata", ls_rdata, m_rdata);
            if (cyc >= iss_cyc && cyc < resp_cyc) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
                if (m_chk_be) check("mem_byte_en", mem_be, m_be);
            end
            if (!exp_busy) begin
                check("idle_mem", {mem_we, mem_be, mem_addr, mem_wdata}, '0);
                check("idle_rdata", {if_rdata, ls_rdata}, '0);
            end
            if (if_valid) begin if_vcyc = cyc; if_vdata = if_rdata; end
            if (ls_valid) begin ls_vcyc = cyc; ls_vdata = ls_rdata; end
            if (ls_gnt) begin
                ls_gcyc = cyc; st_addr = mem_addr; st_wdata = mem_wdata;
                st_be = mem_be; st_we = mem_we;
            end
            if (cyc >= free_cyc && (if_req || ls_req)) begin
                m_ls     = ls_req && (!if_req || !last_m);
                last_m   = m_ls;
                iss_cyc  = cyc + 1;
                resp_cyc = cyc + 2 + LAT;
                free_cyc = resp_cyc;
                if (m_ls) begin
                    by       = BYTE_MODE && ls_byte;
                    lane     = 3 - int'(ls_addr[1:0]);
                    m_addr   = {ls_addr[31:2], 2'b00};
                    m_we     = ls_write;
                    m_be     = by ? 4'(1 << lane) : 4'hF;
                    m_wdata  = by ? {4{ls_wdata[7:0]}} : ls_wdata;
                    m_chk_be = ls_write || !by;
                    word     = ref_mem[ls_addr[9:2]];
                    bv       = word[8*lane +: 8];
                    if (ls_write) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) word[8*b +: 8] = m_wdata[8*b +: 8];
                        ref_mem[ls_addr[9:2]] = word;
                        m_rdata = '0;
                    end else if (by) begin
                        m_rdata = ls_unsigned ? {24'h0, bv} : {{24{bv[7]}}, bv};
                    end else begin
                        m_rdata = word;
                    end
                end else begin
                    m_addr = {if_addr[31:2], 2'b00}; m_we = 0; m_be = 4'hF;
                    m_wdata = '0; m_chk_be = 1; m_rdata = ref_mem[if_addr[9:2]];
                end
            end
        end
    end

    task automatic do_req(input bit ls, input bit wr, input bit by, input bit un,
                          input logic [31:0] addr, input logic [31:0] wd, output int rc);
        bit got;
        rc = cyc;
        if (ls) begin
            ls_req = 1; ls_write = wr; ls_byte = by; ls_unsigned = un;
            ls_addr = addr; ls_wdata = wd;
        end else begin
            if_req = 1; if_addr = addr;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = ls ? ls_gnt : if_gnt;
        end
        check("gnt_seen", got, 1);
        @(posedge clock); #1;
        if (ls) ls_req = 0; else if_req = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = ls ? ls_valid : if_valid;
        end
        check("valid_seen", got, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        int rc, gn, n1, n7, seen;
        int gcyc [3];
        bit gwho [3];
        int v1c, v7c;
        logic [31:0] v1d, v7d;
        reset_n = 0; if_req = 0; if_addr = '0; ls_req = 0; ls_write = 0; ls_byte = 0;
        ls_unsigned = 0; ls_addr = '0; ls_wdata = '0; r1 = 0; r7 = 0; small_addr = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        @(posedge clock); #1;

        // Contention right after reset: ls, fetch, ls with no idle gaps.
        if_req = 1; if_addr = 32'h40; ls_req = 1; ls_write = 0; ls_byte = 0; ls_addr = 32'h100;
        gn = 0;
        for (int i = 0; i < 60 && gn < 3; i++) begin
            @(negedge clock);
            if (if_gnt || ls_gnt) begin gcyc[gn] = cyc; gwho[gn] = ls_gnt; gn++; end
            @(posedge clock); #1;
            if (gn >= 2) if_req = 0;
        end
        ls_req = 0;
        check("contend_count", gn, 3);
        check("contend_first_ls", gwho[0], 1);
        check("contend_second_if", gwho[1], 0);
        check("contend_third_ls", gwho[2], 1);
        check("contend_gap1", gcyc[1] - gcyc[0], 4);
        check("contend_gap2", gcyc[2] - gcyc[1], 4);
        repeat (8) @(posedge clock); #1;

        // Fetch only.
        do_req(0, 0, 0, 0, 32'h40, '0, rc);
        check("fetch_valid_cycle", if_vcyc - rc, 4);
        check("fetch_data", if_vdata, 32'h2408_0005);

        // Byte loads and a byte store.
        do_req(1, 0, 1, 0, 32'h102, '0, rc);
        check("lb_102", ls_vdata, BYTE_MODE ? 32'hFFFF_FFFF : 32'h1280_FF34);
        check("lb_gnt_cycle", ls_gcyc - rc, 1);
        do_req(1, 0, 1, 1, 32'h102, '0, rc);
        check("lbu_102", ls_vdata, BYTE_MODE ? 32'h0000_00FF : 32'h1280_FF34);
        do_req(1, 0, 1, 0, 32'h101, '0, rc);
        check("lb_101", ls_vdata, BYTE_MODE ? 32'hFFFF_FF80 : 32'h1280_FF34);
        do_req(1, 1, 1, 0, 32'h203, 32'h0000_00AB, rc);
        check("sb_be", st_be, BYTE_MODE ? 4'b0001 : 4'b1111);
        check("sb_wdata", st_wdata, BYTE_MODE ? 32'hABAB_ABAB : 32'h0000_00AB);
        check("sb_addr", st_addr, 32'h200);
        check("sb_we", st_we, 1);
        check("sb_rdata", ls_vdata, 0);
        check("sb_valid_cycle", ls_vcyc - rc, 4);
        do_req(1, 0, 0, 0, 32'h200, '0, rc);
        check("lw_after_sb", ls_vdata, BYTE_MODE ? 32'h1122_33AB : 32'h0000_00AB);

        // Reset for one cycle right after ISSUE.
        ls_req = 1; ls_write = 0; ls_byte = 0; ls_addr = 32'h40;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = ls_gnt;
        end
        check("rst_test_gnt", seen, 1);
        @(posedge clock); #1;
        ls_req = 0; reset_n = 0;
        @(posedge clock); #1;
        reset_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (ls_valid || if_valid) seen++;
        end
        check("rst_no_valid", seen, 0);
        @(posedge clock); #1;
        do_req(0, 0, 0, 0, 32'h40, '0, rc);
        check("post_reset_cycle", if_vcyc - rc, 4);
        check("post_reset_data", if_vdata, 32'h2408_0005);

        // Latency 1 and 7.
        small_addr = 32'h80; r1 = 1; r7 = 1; rc = cyc;
        v1c = -1; v7c = -1; v1d = '0; v7d = '0; n1 = 0; n7 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (g1) n1++;
            if (g7) n7++;
            if (v1) begin v1c = cyc; v1d = rd1; end
            if (v7) begin v7c = cyc; v7d = rd7; end
            @(posedge clock); #1;
            if (n1 > 0) r1 = 0;
            if (n7 > 0) r7 = 0;
        end
        check("lat1_gnts", n1, 1);
        check("lat7_gnts", n7, 1);
        check("lat1_valid_cycle", v1c - rc, 3);
        check("lat7_valid_cycle", v7c - rc, 9);
        check("lat1_data", v1d, 32'hFFFF_FF7F);
        check("lat7_data", v7d, 32'hFFFF_FF7F);

        repeat (4) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
